// File: rtl/ysyx_23060203_ram_rd_slave.sv
// AXI4 read-only slave serving FIXED/INCR/WRAP bursts from a 1-cycle synchronous SRAM.
// Optional macro RAM_RDELAY_LFSR_EN adds 0-3 pseudo-random wait cycles per beat.
module ysyx_23060203_ram_rd_slave #(
  parameter int          ID_W    = 4,
  parameter int          MEM_AW  = 20,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          LATENCY = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              arvalid,
  output logic              arready,
  input  logic [31:0]       araddr,
  input  logic [ID_W-1:0]   arid,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  output logic              rvalid,
  input  logic              rready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic [ID_W-1:0]   rid,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, FETCH, RESP} state_t;

  localparam logic [32:0] MEM_LO = {1'b0, BASE};
  localparam logic [32:0] MEM_HI = {1'b0, BASE} + (33'd1 << (MEM_AW + 2));

  state_t          state, state_next;
  logic [31:0]     addr;
  logic [ID_W-1:0] id;
  logic [7:0]      len;
  logic [2:0]      size;
  logic [1:0]      burst;
  logic [7:0]      beat;
  logic [8:0]      delay;
  logic [8:0]      delay_load;
  logic            slverr;
  logic            slverr_new;
  logic            in_range;
  logic [31:0]     step;
  logic [31:0]     wrap_mask;
  logic [31:0]     addr_next;

`ifdef RAM_RDELAY_LFSR_EN
  logic [7:0] lfsr;

  // Free-running Fibonacci LFSR, taps 8,6,5,4.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign delay_load = 9'(LATENCY) + {7'd0, lfsr[1:0]};
`else
  assign delay_load = 9'(LATENCY);
`endif

  assign in_range   = ({1'b0, addr} >= MEM_LO) && ({1'b0, addr} < MEM_HI);
  assign mem_addr   = MEM_AW'((addr - BASE) >> 2);
  assign slverr_new = (arburst == 2'b11) || (arsize > 3'd2) ||
                      ((arburst == 2'b10) && !((arlen == 8'd1) || (arlen == 8'd3) ||
                                               (arlen == 8'd7) || (arlen == 8'd15)));

  assign step      = 32'd1 << size;
  assign wrap_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;

  always_comb begin
    addr_next = addr;
    case (burst)
      2'b01:   addr_next = addr + step;
      2'b10:   addr_next = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
      default: addr_next = addr;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    arready    = 1'b0;
    mem_en     = 1'b0;
    case (state)
      IDLE: begin
        arready = 1'b1;
        if (arvalid) state_next = WAIT;
      end
      WAIT: begin
        if (delay == 9'd0) begin
          mem_en     = in_range && !slverr;
          state_next = FETCH;
        end
      end
      FETCH: state_next = RESP;
      RESP: begin
        if (rready) state_next = rlast ? IDLE : WAIT;
      end
      default: state_next = IDLE;
    endcase
  end

  // Burst context and the registered R channel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr   <= '0;
      id     <= '0;
      len    <= '0;
      size   <= '0;
      burst  <= '0;
      beat   <= '0;
      delay  <= '0;
      slverr <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= '0;
      rlast  <= 1'b0;
      rid    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arvalid) begin
            addr   <= araddr;
            id     <= arid;
            len    <= arlen;
            size   <= arsize;
            burst  <= arburst;
            beat   <= '0;
            delay  <= delay_load;
            slverr <= slverr_new;
          end
        end
        WAIT: begin
          if (delay != 9'd0) delay <= delay - 9'd1;
        end
        FETCH: begin
          rvalid <= 1'b1;
          rdata  <= (in_range && !slverr) ? mem_rdata : 32'd0;
          rresp  <= slverr ? 2'b10 : (in_range ? 2'b00 : 2'b11);
          rlast  <= (beat == len);
          rid    <= id;
        end
        RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            if (!rlast) begin
              beat  <= beat + 8'd1;
              addr  <= addr_next;
              delay <= delay_load;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_ram_rd_slave.sv
// Self-checking bench: directed and random bursts compared against a burst-level reference model.
module tb_ysyx_23060203_ram_rd_slave;

  localparam int          ID_W    = 4;
  localparam int          MEM_AW  = 4;
  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int          LATENCY = 0;
  localparam int          WORDS   = 1 << MEM_AW;

  logic              clock;
  logic              reset;
  logic              arvalid;
  logic              arready;
  logic [31:0]       araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;
  logic              mem_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_rdata;

  logic [31:0] mem [WORDS];
  int          mem_log[$];
  int          test_count = 0;
  int          fail_count = 0;

  ysyx_23060203_ram_rd_slave #(
    .ID_W(ID_W), .MEM_AW(MEM_AW), .BASE(BASE), .LATENCY(LATENCY)
  ) dut (
    .clock(clock), .reset(reset),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM model with one cycle of read latency, plus a log of every access.
  always @(posedge clock) if (mem_en) mem_rdata <= mem[mem_addr];
  always @(negedge clock) if (mem_en) mem_log.push_back(int'(mem_addr));

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] start, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [ID_W-1:0] id,
                               input int stall_beat, input int reset_beat);
    logic [31:0] a, step, bytes, lower;
    logic [31:0] exp_data[$];
    logic [1:0]  exp_resp[$];
    int          exp_maddr[$];
    logic [31:0] held_data;
    logic [1:0]  held_resp;
    bit          slv, inr;
    int          cycles, n;

    // Reference model: per-beat address, response and data from the burst rules.
    slv  = (burst == 2'b11) || (size > 3'd2) ||
           (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    a    = start;
    step = 32'd1 << size;
    for (int k = 0; k <= int'(len); k++) begin
      inr = (64'(a) >= 64'(BASE)) && (64'(a) < 64'(BASE) + 64'(4 * WORDS));
      if (slv) begin
        exp_resp.push_back(2'b10);
        exp_data.push_back(32'd0);
      end else if (!inr) begin
        exp_resp.push_back(2'b11);
        exp_data.push_back(32'd0);
      end else begin
        exp_resp.push_back(2'b00);
        exp_data.push_back(mem[(a - BASE) / 4]);
        exp_maddr.push_back(int'((a - BASE) / 4));
      end
      if (burst == 2'b01) begin
        a = a + step;
      end else if (burst == 2'b10) begin
        bytes = (32'(len) + 32'd1) * step;
        lower = a - (a % bytes);
        a = a + step;
        if (a - lower >= bytes) a = a - bytes;
      end
    end

    mem_log.delete();
    n = 0;
    while (!arready && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("arready_idle", arready, 1);
    arvalid = 1'b1;
    araddr  = start;
    arid    = id;
    arlen   = len;
    arsize  = size;
    arburst = burst;
    @(posedge clock);

    for (int k = 0; k <= int'(len); k++) begin
      cycles = 0;
      do begin
        @(negedge clock);
        cycles++;
        if (cycles == 1) arvalid = 1'b0;
      end while (!rvalid && cycles < 50);
`ifdef RAM_RDELAY_LFSR_EN
      checkOutput("latency_window", (cycles >= 3 + LATENCY) && (cycles <= 6 + LATENCY), 1);
`else
      checkOutput("latency", cycles, 3 + LATENCY);
`endif
      if (!rvalid) return;
      checkOutput("rdata", rdata, exp_data[k]);
      checkOutput("rresp", rresp, exp_resp[k]);
      checkOutput("rlast", rlast, k == int'(len));
      checkOutput("rid", rid, id);
      checkOutput("arready_busy", arready, 0);

      if (k == reset_beat) begin
        rready = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_rvalid", rvalid, 0);
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_arready", arready, 1);
        mem_log.delete();
        @(negedge clock);
        reset  = 1'b0;
        rready = 1'b1;
        repeat (4) begin
          @(negedge clock);
          checkOutput("post_rst_rvalid", rvalid, 0);
        end
        checkOutput("post_rst_mem", mem_log.size(), 0);
        return;
      end

      if (k == stall_beat) begin
        rready    = 1'b0;
        held_data = rdata;
        held_resp = rresp;
        repeat (3) begin
          @(negedge clock);
          checkOutput("stall_rvalid", rvalid, 1);
          checkOutput("stall_rdata", rdata, held_data);
          checkOutput("stall_rresp", rresp, held_resp);
          checkOutput("stall_mem_en", mem_en, 0);
        end
        rready = 1'b1;
      end
      @(posedge clock);
    end

    @(negedge clock);
    checkOutput("arready_after", arready, 1);
    checkOutput("mem_count", mem_log.size(), exp_maddr.size());
    for (int i = 0; i < mem_log.size() && i < exp_maddr.size(); i++)
      checkOutput("mem_addr", mem_log[i], exp_maddr[i]);
  endtask

  initial begin
    reset   = 1'b1;
    arvalid = 1'b0;
    araddr  = '0;
    arid    = '0;
    arlen   = '0;
    arsize  = '0;
    arburst = '0;
    rready  = 1'b1;
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[4] = 32'hDEAD_BEEF;

    repeat (3) @(negedge clock);
    checkOutput("reset_rvalid", rvalid, 0);
    checkOutput("reset_arready", arready, 1);
    checkOutput("reset_mem_en", mem_en, 0);
    checkOutput("reset_rlast", rlast, 0);
    reset = 1'b0;
    @(negedge clock);

    applyStimulus(32'h8000_0010, 8'd0, 3'd2, 2'b01, 4'd3, -1, -1);
    applyStimulus(32'h8000_0000, 8'd3, 3'd2, 2'b01, 4'd5, 1, -1);
    applyStimulus(32'h8000_0008, 8'd3, 3'd2, 2'b10, 4'd1, -1, -1);
    applyStimulus(32'h8000_003C, 8'd1, 3'd2, 2'b01, 4'd7, -1, -1);
    applyStimulus(32'h8000_0000, 8'd2, 3'd2, 2'b11, 4'd2, -1, -1);
    applyStimulus(32'h8000_0000, 8'd3, 3'd2, 2'b01, 4'd9, -1, 1);
    applyStimulus(32'h8000_0010, 8'd0, 3'd2, 2'b01, 4'd3, -1, -1);

    for (int t = 0; t < 40; t++) begin
      applyStimulus(BASE - 32'd16 + 32'($urandom_range(0, 96)), 8'($urandom_range(0, 7)),
                    3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 7)) : -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/ysyx_23060203_ram_rd_slave.md
Name: ysyx_23060203_ram_rd_slave

Overview:
- AXI4 read-only slave that sits directly downstream of the IFU/LSU read arbiter and serves its `ram_r` channel.
- Accepts one AR request at a time and walks FIXED/INCR/WRAP bursts.
- Each beat reads one word from an external synchronous single-port SRAM (1-cycle read latency).
- Each beat is returned on R with a programmable access delay.

Parameters:
- ID_W, 4, width of arid/rid.
- MEM_AW, 20, SRAM word-address width (capacity 2^MEM_AW 32-bit words).
- BASE, 32'h8000_0000, byte address mapped to SRAM word 0.
- LATENCY, 0, extra wait cycles inserted before every SRAM access (0..255).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- araddr  in  32  byte address of first beat
- arid  in  ID_W  transaction ID
- arlen  in  8  beats minus 1
- arsize  in  3  log2 bytes per beat
- arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- rvalid  out  1  R valid
- rready  in  1  R ready
- rdata  out  32  read word (full aligned word; narrow lanes in natural byte position)
- rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- rlast  out  1  last beat
- rid  out  ID_W  echoed arid
- mem_en  out  1  SRAM read strobe
- mem_addr  out  MEM_AW  SRAM word index = (addr-BASE)>>2
- mem_rdata  in  32  SRAM data, valid the cycle after mem_en

Behaviour:
- Single clock domain: `clock`. Reset is asynchronous and active-high on `reset`.
- Reset (asynchronous, takes effect immediately, including mid-burst):
  - state=IDLE; all registered outputs 0 (arready is 1 in IDLE).
  - Partial bursts are abandoned; no further beats are sent after reset release.
- States:
  - IDLE: arready=1, rvalid=0, mem_en=0. On arvalid&arready: latch addr/id/len/size/burst; beat=0; delay=LATENCY; compute error flag; go WAIT.
  - WAIT: arready=0. If delay!=0, decrement. If delay==0: if beat is in range and there is no error, drive mem_en=1 with mem_addr for the current addr; go FETCH.
  - FETCH: on the edge ending this cycle, capture rdata=mem_rdata (or 0 on error), rresp, rlast=(beat==len), rid, and set rvalid=1; go RESP.
  - RESP: rvalid, rdata, rresp, rlast and rid are held stable until rready.
    - On handshake with rlast: rvalid=0; go IDLE. arready is not asserted in this cycle; the next AR is accepted one cycle later.
    - Otherwise: rvalid=0; beat++; advance addr; delay=LATENCY; go WAIT.
- Latency: the first rvalid rises at edge E0+2+LATENCY, where E0 is the AR handshake edge. Each later beat rises at Ek+2+LATENCY, where Ek is the previous R handshake edge. No overlap between beats.
- Address advance:
  - FIXED: unchanged.
  - INCR: addr += 1<<size, 32-bit wrap-around.
  - WRAP: mask=((len+1)<<size)-1; addr=(addr&~mask)|((addr+(1<<size))&mask).
- Errors (the burst still delivers len+1 beats with correct rlast/rid, rdata=0, no mem_en):
  - arburst=11, arsize>2, or WRAP with len not in {1,3,7,15} → SLVERR on all beats.
  - Per beat: addr<BASE or addr>=BASE+(4<<MEM_AW) → DECERR for that beat only.
  - SLVERR takes precedence over DECERR.
- Unaligned INCR start: mem_addr ignores addr[1:0]; the beat is still OKAY.
- rready held high during RESP: the handshake completes in the first RESP cycle.

Optional Feature:
- Macro RAM_RDELAY_LFSR_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded to 8'hA5 on reset and advances every cycle.
  - Every delay load becomes LATENCY+lfsr[1:0], so each beat gets 0–3 extra wait cycles, deterministic for a given reset point.
- Undefined: the delay is exactly LATENCY; no LFSR logic is present.

Test Plan:
- Single beat (LATENCY=0): AR 0x8000_0010, len=0, size=2, INCR, id=3, with SRAM word 4=0xDEADBEEF.
  - mem_en/mem_addr=4 one cycle after the handshake.
  - rvalid at E0+2 with rdata=0xDEADBEEF, rresp=00, rlast=1, rid=3.
  - arready back to 1 in the second cycle after the R handshake.
- INCR len=3 from 0x8000_0000 with rready low for 3 cycles on beat 1: mem_addr 0,1,2,3 in order; beat 1 outputs held stable while stalled; rlast only on beat 3.
- WRAP len=3, size=2, start 0x8000_0008: mem_addr sequence 2,3,0,1; all OKAY.
- Out of range (MEM_AW=4): INCR len=1 from 0x8000_003C → beat0 OKAY (word 15), beat1 DECERR, rdata=0, no mem_en on beat1.
- Reserved burst=11 len=2 → 3 beats, all SLVERR, rdata=0, mem_en never asserted, rlast on third beat.
- Reset asserted during RESP of beat 1 of a len=3 burst:
  - rvalid and mem_en drop immediately.
  - After release, arready=1 and a new single-beat read completes normally.
